// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader that writes 16-bit words into instruction memory
module program_loader #(
    parameter int ADDR_W    = 7,
    parameter int MAX_WORDS = 128,
    parameter int TIMEOUT   = 1000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    output logic              RxReady,
    output logic [ADDR_W-1:0] IM_addr,
    output logic [15:0]       IM_wdata,
    output logic              IM_wr,
    output logic              CPU_hold,
    output logic              Done,
    output logic              Error,
    output logic [7:0]        WordCount,
    output logic [3:0]        StateOut
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_HDR   = 4'd1,
        S_LEN   = 4'd2,
        S_HI    = 4'd3,
        S_LO    = 4'd4,
        S_WRITE = 4'd5,
        S_CSUM  = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  word_count, word_count_nx;
    logic [7:0]  len, len_nx;
    logic [7:0]  csum, csum_nx;
    logic [7:0]  hi, hi_nx;
    logic [7:0]  lo, lo_nx;
    logic        illegal, illegal_nx;
    logic [31:0] timer, timer_nx;
    logic        timed;
    logic        xfer;

    assign xfer = RxValid & RxReady;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            word_count <= 8'd0;
            len        <= 8'd0;
            csum       <= 8'd0;
            hi         <= 8'd0;
            lo         <= 8'd0;
            illegal    <= 1'b0;
            timer      <= 32'd0;
        end else begin
            state      <= state_nx;
            word_count <= word_count_nx;
            len        <= len_nx;
            csum       <= csum_nx;
            hi         <= hi_nx;
            lo         <= lo_nx;
            illegal    <= illegal_nx;
            timer      <= timer_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        word_count_nx = word_count;
        len_nx        = len;
        csum_nx       = csum;
        hi_nx         = hi;
        lo_nx         = lo;
        illegal_nx    = illegal;
        timer_nx      = timer;
        RxReady       = 1'b0;
        timed         = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    state_nx      = S_HDR;
                    word_count_nx = 8'd0;
                    csum_nx       = 8'd0;
                    illegal_nx    = 1'b0;
                    timer_nx      = 32'd0;
                end
            end
            S_HDR: begin
                RxReady = 1'b1;
                if (xfer && RxData == 8'hA5) state_nx = S_LEN;
            end
            S_LEN: begin
                RxReady = 1'b1;
                timed   = 1'b1;
                if (xfer) begin
                    if (RxData == 8'd0 || {24'd0, RxData} > 32'(MAX_WORDS)) begin
                        state_nx = S_ERR;
                    end else begin
                        len_nx   = RxData;
                        state_nx = S_HI;
                    end
                end
            end
            S_HI: begin
                RxReady = 1'b1;
                timed   = 1'b1;
                if (xfer) begin
                    hi_nx   = RxData;
                    csum_nx = csum ^ RxData;
                    if (RxData[7:4] > 4'd5) illegal_nx = 1'b1;
                    state_nx = S_LO;
                end
            end
            S_LO: begin
                RxReady = 1'b1;
                timed   = 1'b1;
                if (xfer) begin
                    lo_nx    = RxData;
                    csum_nx  = csum ^ RxData;
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                word_count_nx = word_count + 8'd1;
                state_nx      = (word_count + 8'd1 == len) ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                RxReady = 1'b1;
                timed   = 1'b1;
                if (xfer) state_nx = (RxData == csum && !illegal) ? S_DONE : S_ERR;
            end
            default: state_nx = S_IDLE;
        endcase
        // Inter-byte watchdog; a transfer restarts it, HDR waits forever
        if (timed) begin
            if (xfer) begin
                timer_nx = 32'd0;
            end else begin
                timer_nx = timer + 32'd1;
                if (TIMEOUT != 0 && timer_nx == 32'(TIMEOUT)) state_nx = S_ERR;
            end
        end
    end

    assign IM_wr     = (state == S_WRITE);
    assign IM_addr   = word_count[ADDR_W-1:0];
    assign IM_wdata  = {hi, lo};
    assign Done      = (state == S_DONE);
    assign Error     = (state == S_ERR);
    assign CPU_hold  = (state != S_DONE);
    assign WordCount = word_count;
    assign StateOut  = state;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized scoreboard bench for program_loader
module tb_program_loader;
    localparam int ADDR_W    = 7;
    localparam int MAX_WORDS = 128;
    localparam int TIMEOUT   = 20;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          kind;   // 0 write, 1 done, 2 error
        logic [6:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic              Clk, Reset, Start, RxValid;
    logic [7:0]        RxData;
    logic              RxReady, IM_wr, CPU_hold, Done, Error;
    logic [ADDR_W-1:0] IM_addr;
    logic [15:0]       IM_wdata;
    logic [7:0]        WordCount;
    logic [3:0]        StateOut;

    int  errors = 0;
    int  checks = 0;
    ev_t exp_q[$];
    logic done_q = 1'b0, err_q = 1'b0;

    program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .RxData(RxData), .RxValid(RxValid),
        .RxReady(RxReady), .IM_addr(IM_addr), .IM_wdata(IM_wdata), .IM_wr(IM_wr),
        .CPU_hold(CPU_hold), .Done(Done), .Error(Error), .WordCount(WordCount),
        .StateOut(StateOut)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (e.kind == 0 && kind == 0) begin
                chk("im_addr", 32'(IM_addr), 32'(e.addr));
                chk("im_wdata", 32'(IM_wdata), 32'(e.data));
            end
            if (kind != 0) begin
                chk("done_error_excl", 32'(Done & Error), 32'd0);
                chk("cpu_hold_vs_done", 32'(CPU_hold), 32'(!Done));
            end
        end
    endtask

    // Monitor: consumes expectations whenever the DUT produces an observable event
    always @(negedge Clk) begin
        if (IM_wr) pop_check(0);
        if (Done && !done_q) pop_check(1);
        if (Error && !err_q) pop_check(2);
        done_q <= Done;
        err_q  <= Error;
    end

    task automatic push_ev(input int kind, input int addr, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr[6:0];
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        RxValid = 1'b0;
        repeat (gap) begin
            @(posedge Clk); #1;
        end
        RxData  = b;
        RxValid = 1'b1;
        n = 0;
        while (!RxReady && n < 300) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!RxReady) chk("rxready_timeout", 32'(RxReady), 32'd1);
        @(posedge Clk); #1;
        RxValid = 1'b0;
    endtask

    task automatic wait_outcome();
        int n;
        n = 0;
        while (!(Done || Error) && n < 400) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!(Done || Error)) chk("outcome_timeout", 32'(Done | Error), 32'd1);
        @(negedge Clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    function automatic logic [7:0] xor_of(input bq_t d);
        logic [7:0] x = 8'd0;
        foreach (d[i]) x ^= d[i];
        return x;
    endfunction

    // Reference model: expected writes and verdict follow from the frame contents alone
    task automatic run_frame(input bq_t garbage, input logic [7:0] n, input bq_t d,
                             input logic [7:0] cs, input int gap);
        logic ill;
        int   words;
        ill   = 1'b0;
        words = 0;
        if (n == 0 || int'(n) > MAX_WORDS) begin
            push_ev(2, 0, 16'h0);
        end else begin
            words = int'(n);
            for (int i = 0; i < words; i++) begin
                push_ev(0, i, {d[2*i], d[2*i+1]});
                if (d[2*i][7:4] > 4'd5) ill = 1'b1;
            end
            push_ev((cs == xor_of(d) && !ill) ? 1 : 2, 0, 16'h0);
        end
        pulse_start();
        foreach (garbage[i]) send_byte(garbage[i], gap);
        send_byte(8'hA5, gap);
        send_byte(n, gap);
        if (words != 0) begin
            foreach (d[i]) send_byte(d[i], gap);
            send_byte(cs, gap);
        end
        wait_outcome();
        chk("word_count", 32'(WordCount), 32'(words));
    endtask

    initial begin
        bq_t g, d;
        logic [7:0] n, cs;
        Reset = 1'b0; Start = 1'b0; RxData = 8'd0; RxValid = 1'b0;
        repeat (3) @(posedge Clk); #1;
        chk("rst_state", 32'(StateOut), 32'd0);
        chk("rst_cpu_hold", 32'(CPU_hold), 32'd1);
        chk("rst_rxready", 32'(RxReady), 32'd0);
        chk("rst_im_wr", 32'(IM_wr), 32'd0);
        chk("rst_done_err", 32'({Done, Error}), 32'd0);
        chk("rst_wordcount", 32'(WordCount), 32'd0);
        chk("rst_im_bus", 32'({IM_addr, IM_wdata}), 32'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("idle_without_start", 32'(StateOut), 32'd0);

        g = {};
        d = {8'h3D, 8'hEF, 8'h50, 8'h00};
        run_frame(g, 8'h02, d, 8'h82, 0);
        chk("valid_done", 32'({Done, Error, CPU_hold}), 32'b100);

        run_frame(g, 8'h02, d, 8'h83, 0);
        chk("badcs_error", 32'({Done, Error, CPU_hold}), 32'b011);
        pulse_start();
        chk("start_clears_error", 32'({Error, StateOut}), 32'h1);
        chk("start_hold", 32'(CPU_hold), 32'd1);

        d = {8'h7A, 8'h00};
        run_frame(g, 8'h01, d, 8'h7A, 0);
        run_frame(g, 8'h00, d, 8'h00, 0);
        run_frame(g, 8'h81, d, 8'h00, 0);

        g = {8'h11, 8'h22};
        d = {8'h3D, 8'hEF, 8'h50, 8'h00};
        run_frame(g, 8'h02, d, 8'h82, 0);
        g = {};
        run_frame(g, 8'h02, d, 8'h82, 5);
        chk("gapped_done", 32'(Done), 32'd1);

        // Stall after LEN until the watchdog fires
        push_ev(2, 0, 16'h0);
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        repeat (15) begin
            @(posedge Clk); #1;
        end
        chk("stall_still_hi", 32'({Error, StateOut}), 32'h3);
        wait_outcome();
        chk("timeout_error", 32'({Error, CPU_hold}), 32'b11);

        // Reset while waiting for a low byte
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h3D, 0);
        chk("pre_reset_in_lo", 32'(StateOut), 32'd4);
        Reset = 1'b0;
        #1;
        chk("midreset_state", 32'(StateOut), 32'd0);
        chk("midreset_hold_wc", 32'({CPU_hold, WordCount}), 32'h100);
        chk("midreset_imwr", 32'(IM_wr), 32'd0);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("post_reset_idle", 32'(StateOut), 32'd0);
        run_frame(g, 8'h02, d, 8'h82, 0);
        chk("reload_done", 32'(Done), 32'd1);

        d = {};
        for (int i = 0; i < 2 * MAX_WORDS; i++) d.push_back(8'($urandom_range(0, 8'h5F)));
        run_frame(g, 8'(MAX_WORDS), d, xor_of(d), 0);

        for (int f = 0; f < 12; f++) begin
            g = {};
            repeat ($urandom_range(0, 2)) g.push_back(8'($urandom_range(0, 8'h7F)));
            n = 8'($urandom_range(1, 6));
            d = {};
            for (int i = 0; i < 2 * int'(n); i++) begin
                if (i % 2 == 0 && $urandom_range(0, 5) != 0)
                    d.push_back({4'($urandom_range(0, 5)), 4'($urandom)});
                else
                    d.push_back(8'($urandom));
            end
            cs = xor_of(d);
            if ($urandom_range(0, 4) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            run_frame(g, n, d, cs, $urandom_range(0, 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
